// File: rtl/round_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : round_timer_ctrl
// Description: Game-round sequencer for a 3-bit countdown timer: 1 s tick,
//              arm/run/result round flow, hit/timeout scoring, game end.
//              Optional: ROUND_CTRL_ABORT_EN (start_btn mid-game returns to IDLE).
// Revision   : 1.0 - initial release
// ============================================================================
module round_timer_ctrl #(
   parameter int TICK_DIV     = 100_000_000,
   parameter int ROUNDS       = 5,
   parameter int GAP_TICKS    = 1,
   parameter int RESULT_TICKS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       hit_btn,
   input  logic [2:0] timer_val,
   output logic       timer_run,
   output logic       sec_tick,
   output logic [2:0] state,
   output logic [3:0] round_num,
   output logic [3:0] score,
   output logic       last_hit,
   output logic       done
);

   localparam int PRE_W    = $clog2(TICK_DIV);
   localparam int TICK_MAX = (GAP_TICKS > RESULT_TICKS) ? GAP_TICKS : RESULT_TICKS;
   localparam int TCNT_W   = $clog2(TICK_MAX + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);
   localparam logic [TCNT_W-1:0] RES_LAST  = TCNT_W'(RESULT_TICKS - 1);
   localparam logic [3:0]        LAST_RND  = 4'(ROUNDS);
   localparam logic [3:0]        SCORE_MAX = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_RUN    = 3'd2,
      S_RESULT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              cur_state;
   state_t              nxt_state;
   logic [PRE_W-1:0]    pre_cnt;
   logic [PRE_W-1:0]    pre_nxt;
   logic [TCNT_W-1:0]   tick_cnt;
   logic [3:0]          nxt_round;
   logic [3:0]          nxt_score;
   logic                nxt_last_hit;
   logic                state_change;
   logic                pre_clear;

   // ------------------------------------------------------------------------
   // Next-state and round bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      nxt_state    = cur_state;
      nxt_round    = round_num;
      nxt_score    = score;
      nxt_last_hit = last_hit;

      case (cur_state)
         S_IDLE: begin
            if (start_btn) begin
               nxt_state    = S_ARM;
               nxt_round    = 4'd1;
               nxt_score    = 4'd0;
               nxt_last_hit = 1'b0;
            end
         end
         S_ARM: begin
            if (sec_tick && (tick_cnt == GAP_LAST)) begin
               nxt_state = S_RUN;
            end
         end
         S_RUN: begin
            // Timeout is checked first so a hit on the zero count is a miss.
            if (timer_val == 3'd0) begin
               nxt_state    = S_RESULT;
               nxt_last_hit = 1'b0;
            end else if (hit_btn) begin
               nxt_state    = S_RESULT;
               nxt_last_hit = 1'b1;
               nxt_score    = (score == SCORE_MAX) ? score : score + 4'd1;
            end
         end
         S_RESULT: begin
            if (sec_tick && (tick_cnt == RES_LAST)) begin
               if (round_num == LAST_RND) begin
                  nxt_state = S_DONE;
               end else begin
                  nxt_state = S_ARM;
                  nxt_round = round_num + 4'd1;
               end
            end
         end
         S_DONE: begin
            if (start_btn) begin
               nxt_state = S_ARM;
               nxt_round = 4'd1;
               nxt_score = 4'd0;
            end
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase

`ifdef ROUND_CTRL_ABORT_EN
      if (start_btn && ((cur_state == S_ARM) || (cur_state == S_RUN) ||
                        (cur_state == S_RESULT))) begin
         nxt_state    = S_IDLE;
         nxt_round    = 4'd0;
         nxt_score    = 4'd0;
         nxt_last_hit = 1'b0;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Prescaler: restarts on entry to a timed state so its first tick lands a
   // full TICK_DIV period after entry.
   // ------------------------------------------------------------------------
   always_comb begin
      state_change = (nxt_state != cur_state);
      pre_clear    = state_change &&
                     ((nxt_state == S_ARM) || (nxt_state == S_RUN) ||
                      (nxt_state == S_RESULT));
      if (pre_clear || (pre_cnt == PRE_LAST)) begin
         pre_nxt = '0;
      end else begin
         pre_nxt = pre_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt   <= '0;
         sec_tick  <= 1'b0;
         tick_cnt  <= '0;
         timer_run <= 1'b0;
         round_num <= 4'd0;
         score     <= 4'd0;
         last_hit  <= 1'b0;
         done      <= 1'b0;
      end else begin
         pre_cnt   <= pre_nxt;
         sec_tick  <= (pre_nxt == PRE_LAST);
         if (state_change) begin
            tick_cnt <= '0;
         end else if (sec_tick && ((cur_state == S_ARM) || (cur_state == S_RESULT))) begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         timer_run <= (cur_state == S_RUN);
         round_num <= nxt_round;
         score     <= nxt_score;
         last_hit  <= nxt_last_hit;
         done      <= (nxt_state == S_DONE) && (cur_state != S_DONE);
      end
   end

   assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for round_timer_ctrl: randomized rounds against a round-level
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_round_timer_ctrl;

   localparam int TICK_DIV     = 4;
   localparam int ROUNDS       = 3;
   localparam int GAP_TICKS    = 1;
   localparam int RESULT_TICKS = 2;
   localparam int BUDGET       = 400;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_btn;
   logic       hit_btn;
   logic [2:0] timer_val;
   logic       timer_run;
   logic       sec_tick;
   logic [2:0] state;
   logic [3:0] round_num;
   logic [3:0] score;
   logic       last_hit;
   logic       done;

   round_timer_ctrl #(
      .TICK_DIV    (TICK_DIV),
      .ROUNDS      (ROUNDS),
      .GAP_TICKS   (GAP_TICKS),
      .RESULT_TICKS(RESULT_TICKS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start_btn(start_btn),
      .hit_btn  (hit_btn),
      .timer_val(timer_val),
      .timer_run(timer_run),
      .sec_tick (sec_tick),
      .state    (state),
      .round_num(round_num),
      .score    (score),
      .last_hit (last_hit),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Behavioural countdown timer: reloads to 5 while stopped.
   logic [2:0] tval;
   always @(posedge clk or posedge reset) begin
      if (reset)                      tval <= 3'd5;
      else if (!timer_run)            tval <= 3'd5;
      else if (sec_tick && tval != 0) tval <= tval - 3'd1;
   end
   assign timer_val = tval;

   typedef struct {
      int rnd;
      int hit;
      int sc;
   } res_t;

   res_t res_q[$];
   int   done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   games_expected = 0;
   int   m_score = 0;
   int   m_round = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic finish_bench();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Called at a negedge; waits until state (and optionally timer value) match.
   task automatic wait_for(input int st, input int tv, input string what);
      int n = 0;
      while (!(int'(state) == st && (tv < 0 || int'(timer_val) == tv))) begin
         @(negedge clk);
         n++;
         if (n > BUDGET) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: state %0d timer %0d", what, state, timer_val);
            finish_bench();
         end
      end
   endtask

   task automatic pulse_start();
      start_btn = 1'b1;
      @(negedge clk);
      start_btn = 1'b0;
   endtask

   task automatic pulse_hit();
      hit_btn = 1'b1;
      @(negedge clk);
      hit_btn = 1'b0;
   endtask

   // mode 0: hit at timer value v; 1: no hit (timeout); 2: hit on the zero count
   task automatic play_round(input int mode, input int v);
      res_t r;
      wait_for(2, -1, "run_entry");
      r.rnd = m_round;
      case (mode)
         0: begin
            wait_for(2, v, "hit_point");
            m_score = (m_score + 1 > 15) ? 15 : m_score + 1;
            r.hit = 1; r.sc = m_score;
            res_q.push_back(r);
            pulse_hit();
         end
         1: begin
            r.hit = 0; r.sc = m_score;
            res_q.push_back(r);
         end
         default: begin
            wait_for(2, 0, "zero_count");
            r.hit = 0; r.sc = m_score;
            res_q.push_back(r);
            pulse_hit();
         end
      endcase
      wait_for(3, -1, "result");
      if ($urandom_range(0, 1) == 1) pulse_hit();
      if (m_round == ROUNDS) begin
         done_q.push_back(m_score);
         games_expected++;
         wait_for(4, -1, "done");
      end else begin
         m_round++;
      end
   endtask

   task automatic play_game(input int forced, input int v);
      pulse_start();
      m_round = 1;
      m_score = 0;
      if ($urandom_range(0, 1) == 1) pulse_hit();
      for (int r = 1; r <= ROUNDS; r++) begin
         if (forced >= 0) play_round(forced, v);
         else             play_round($urandom_range(0, 2), $urandom_range(1, 5));
      end
   endtask

   // Monitor: pops the scoreboard on round results and done pulses, and
   // checks state durations and timer_run lag.
   initial begin
      int   prev_state = 0;
      int   run_len    = 0;
      res_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_state = 0;
            run_len    = 0;
         end else begin
            check("timer_run_lag", int'(timer_run), (prev_state == 2) ? 1 : 0);
            if (int'(state) == 3 && prev_state != 3) begin
               if (res_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_result: round %0d last_hit %0d", round_num, last_hit);
               end else begin
                  e = res_q.pop_front();
                  check("round_num", int'(round_num), e.rnd);
                  check("last_hit",  int'(last_hit),  e.hit);
                  check("score",     int'(score),     e.sc);
               end
            end
            if (done) begin
               done_seen++;
               check("done_state", int'(state), 4);
               if (done_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: score %0d expected no pulse", score);
               end else begin
                  check("final_score", int'(score), done_q.pop_front());
               end
            end
            if (int'(state) != prev_state) begin
               if (prev_state == 1) check("arm_len", run_len, GAP_TICKS * TICK_DIV);
               if (prev_state == 3) check("result_len", run_len, RESULT_TICKS * TICK_DIV);
               run_len = 1;
            end else begin
               run_len++;
            end
            prev_state = int'(state);
         end
      end
   end

   initial begin
      int n;
      reset     = 1'b1;
      start_btn = 1'b0;
      hit_btn   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state",     int'(state),     0);
      check("rst_round",     int'(round_num), 0);
      check("rst_score",     int'(score),     0);
      check("rst_last_hit",  int'(last_hit),  0);
      check("rst_timer_run", int'(timer_run), 0);
      check("rst_sec_tick",  int'(sec_tick),  0);
      check("rst_done",      int'(done),      0);
      reset = 1'b0;

      // sec_tick period while idle
      n = 0;
      while (!sec_tick && n < BUDGET) begin @(negedge clk); n++; end
      n = 0;
      do begin @(negedge clk); n++; end while (!sec_tick && n < BUDGET);
      check("tick_period", n, TICK_DIV);

      pulse_hit();
      @(negedge clk);
      check("idle_hit_state", int'(state),     0);
      check("idle_hit_score", int'(score),     0);
      check("idle_hit_round", int'(round_num), 0);

      play_game(0, 3);
      check("all_hit_score", int'(score), 3);
      check("all_hit_last",  int'(last_hit), 1);
      check("all_hit_state", int'(state), 4);

      play_game(1, 0);
      check("all_miss_score", int'(score), 0);
      check("all_miss_last",  int'(last_hit), 0);

      play_game(2, 0);
      check("zero_hit_score", int'(score), 0);

      for (int g = 0; g < 5; g++) play_game(-1, 0);

      // reset in the middle of a RUN with a nonzero score
      pulse_start();
      m_round = 1;
      m_score = 0;
      play_round(0, 4);
      wait_for(2, -1, "run2");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_state",     int'(state),     0);
      check("midrst_score",     int'(score),     0);
      check("midrst_round",     int'(round_num), 0);
      check("midrst_timer_run", int'(timer_run), 0);
      check("midrst_done",      int'(done),      0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // start_btn during RUN
      pulse_start();
      m_round = 1;
      m_score = 0;
      play_round(0, 2);
      wait_for(2, -1, "run_abort");
      pulse_start();
`ifdef ROUND_CTRL_ABORT_EN
      check("abort_state",    int'(state),     0);
      check("abort_score",    int'(score),     0);
      check("abort_round",    int'(round_num), 0);
      check("abort_last_hit", int'(last_hit),  0);
`else
      check("noabort_state", int'(state),     2);
      check("noabort_score", int'(score),     m_score);
      check("noabort_round", int'(round_num), m_round);
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      repeat (20) @(negedge clk);
      check("pending_results", res_q.size(), 0);
      check("pending_done",    done_q.size(), 0);
      check("done_pulses",     done_seen, games_expected);
      finish_bench();
   end

endmodule
`default_nettype wire
